// File: rtl/sw_priority_display.sv
// sw_priority_display: synchronised, debounced switch bank, priority-encoded
// (lowest index wins, value = index+1) onto NUM_DIGITS active-low 7-seg digits.
//
// Parameters:
//   N_SW            number of switches (>= 1)
//   NUM_DIGITS      display digits; N_SW must be < 10**NUM_DIGITS
//   DEBOUNCE_CYCLES cycles a synchronised level must hold before acceptance
//
// Ports:
//   CLK    rising-edge clock
//   RST    synchronous active-high reset
//   SW     raw asynchronous switches
//   DISP   digit d = DISP[8d+7:8d], {dp,g,f,e,d,c,b,a}, active-low, digit 0 right
//   VALUE  registered encoded value, 0 = no switch on
//   CHG    one-cycle pulse alongside a VALUE update that changed it
//
// Build option:
//   SWP_HOLD_EN  when defined, VALUE/DISP hold the last nonzero value while
//                every switch is off; only RST blanks the display again.

module sw_priority_display #(
    parameter int N_SW            = 9,
    parameter int NUM_DIGITS      = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [N_SW-1:0]              SW,
    output logic [8*NUM_DIGITS-1:0]      DISP,
    output logic [$clog2(N_SW+1)-1:0]    VALUE,
    output logic                         CHG
);

    localparam int VW = $clog2(N_SW + 1);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    // The counter flips the debounced bit on the edge it would reach
    // DEBOUNCE_CYCLES, so the last stored count is one less.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_SW-1:0]         sync1;
    logic [N_SW-1:0]         sync2;
    logic [N_SW-1:0]         deb;
    logic [CW-1:0]           cnt [N_SW];
    logic [VW-1:0]           enc;
    logic [VW-1:0]           value_q;
    logic                    chg_q;
    logic                    load;
    logic [8*NUM_DIGITS-1:0] disp_d;
    logic [8*NUM_DIGITS-1:0] disp_q;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= SW;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            deb <= '0;
            for (int i = 0; i < N_SW; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SW; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Scan high to low so the lowest set index is the final assignment.
    always_comb begin
        enc = '0;
        for (int i = N_SW - 1; i >= 0; i--) begin
            if (deb[i]) begin
                enc = VW'(i + 1);
            end
        end
    end

`ifdef SWP_HOLD_EN
    assign load = (enc != '0);
`else
    assign load = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            value_q <= '0;
            chg_q   <= 1'b0;
        end else begin
            chg_q <= load && (enc != value_q);
            if (load) begin
                value_q <= enc;
            end
        end
    end

    // Peel decimal digits off the value; once the remaining quotient is
    // zero every higher digit is a leading zero and stays blank.
    always_comb begin
        logic [31:0] v;
        disp_d = '1;
        v      = 32'(value_q);
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (v != 32'd0) begin
                disp_d[8*d +: 8] = seg7(4'(v % 32'd10));
            end
            v = v / 32'd10;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            disp_q <= '1;
        end else begin
            disp_q <= disp_d;
        end
    end

    assign DISP  = disp_q;
    assign VALUE = value_q;
    assign CHG   = chg_q;

endmodule

// File: tb/tb_sw_priority_display.sv
// tb_sw_priority_display: directed stimulus with a cycle-stamped scoreboard
// of expected VALUE/DISP/CHG, checked on the falling edge.

module tb_sw_priority_display;

`ifdef SWP_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] sw  = 12'hFFF;
    logic [15:0] disp;
    logic [3:0]  value;
    logic        chg;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    int step_id  = 0;

    typedef struct packed {
        int          at;
        int          step;
        int          off;
        logic [3:0]  v;
        logic [15:0] d;
        logic        c;
    } exp_t;

    exp_t sb[$];

    sw_priority_display #(
        .N_SW(12),
        .NUM_DIGITS(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .SW(sw),
        .DISP(disp),
        .VALUE(value),
        .CHG(chg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                exp_t e;
                e = sb[i];
                checks++;
                assert (value === e.v) else begin
                    failures++;
                    $error("FAIL s%0d+%0d VALUE obs=%h exp=%h",
                           e.step, e.off, value, e.v);
                end
                checks++;
                assert (disp === e.d) else begin
                    failures++;
                    $error("FAIL s%0d+%0d DISP obs=%h exp=%h",
                           e.step, e.off, disp, e.d);
                end
                checks++;
                assert (chg === e.c) else begin
                    failures++;
                    $error("FAIL s%0d+%0d CHG obs=%b exp=%b",
                           e.step, e.off, chg, e.c);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_win(input int first, input int last,
                              input logic [3:0] v, input logic [15:0] d,
                              input logic c);
        for (int o = first; o <= last; o++) begin
            exp_t e;
            e = '{at: cyc + o, step: step_id, off: o, v: v, d: d, c: c};
            sb.push_back(e);
        end
    endtask

    // Drive a new switch word at a falling edge: capture happens at the next
    // rising edge, VALUE/CHG follow 6 edges later and DISP one after that.
    task automatic change(input logic [11:0] s,
                          input logic [3:0] v0, input logic [15:0] d0,
                          input logic [3:0] v1, input logic [15:0] d1,
                          input logic c1);
        step_id++;
        sw = s;
        expect_win(1, 6, v0, d0, 1'b0);
        expect_win(7, 7, v1, d0, c1);
        expect_win(8, 9, v1, d1, 1'b0);
        repeat (9) @(negedge clk);
    endtask

    initial begin
        logic [3:0]  v_off;
        logic [15:0] d_off;

        rst = 1'b1;
        sw  = 12'hFFF;
        expect_win(1, 2, 4'd0, 16'hFFFF, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        change(12'hFFF, 4'd0, 16'hFFFF, 4'd1, 16'hFFF9, 1'b1);

        change(12'h000, 4'd1, 16'hFFF9,
               HOLD ? 4'd1 : 4'd0, HOLD ? 16'hFFF9 : 16'hFFFF, !HOLD);
        change(12'h001, HOLD ? 4'd1 : 4'd0, HOLD ? 16'hFFF9 : 16'hFFFF,
               4'd1, 16'hFFF9, !HOLD);

        change(12'h0A0, 4'd1, 16'hFFF9, 4'd6, 16'hFF82, 1'b1);

        step_id++;
        sw = 12'h0A1;
        expect_win(1, 12, 4'd6, 16'hFF82, 1'b0);
        repeat (3) @(negedge clk);
        sw = 12'h0A0;
        repeat (9) @(negedge clk);

        change(12'h800, 4'd6, 16'hFF82, 4'd12, 16'hF9A4, 1'b1);
        change(12'h802, 4'd12, 16'hF9A4, 4'd2, 16'hFFA4, 1'b1);
        change(12'h800, 4'd2, 16'hFFA4, 4'd12, 16'hF9A4, 1'b1);

        v_off = HOLD ? 4'd12 : 4'd0;
        d_off = HOLD ? 16'hF9A4 : 16'hFFFF;
        change(12'h000, 4'd12, 16'hF9A4, v_off, d_off, !HOLD);

        step_id++;
        sw = 12'h010;
        expect_win(1, 3, v_off, d_off, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        expect_win(1, 1, 4'd0, 16'hFFFF, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        change(12'h010, 4'd0, 16'hFFFF, 4'd5, 16'hFF92, 1'b1);

        repeat (2) @(negedge clk);
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
